// File: rtl/pipe_freeze_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_freeze_ctrl
// Description : Central stall/flush sequencer for the front end. Merges the
//               structural-full flags and the retire-stage exception report
//               into freeze_front / freeze_back / flush. Runs a
//               RUN -> FLUSH -> RECOVER sequence so rename/issue state can be
//               restored from the architectural RAT before fetch restarts.
//               Also keeps stall/exception statistics and a stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_freeze_ctrl #(
    parameter int RECOVER_CYC   = 2,    // freeze_front cycles held after flush (>=1)
    parameter int STALL_TIMEOUT = 255,  // consecutive stall cycles before deadlock
    parameter int CNT_W         = 16    // stall_cycles counter width
) (
    input  logic             clk,
    input  logic             rst,           // asynchronous, active-low
    input  logic             full_PRF,
    input  logic             full_RS_add,
    input  logic             full_RS_mul,
    input  logic             full_RS_agu,
    input  logic             full_LSQ,
    input  logic             full_ROB,
    input  logic             mem_busy,
    input  logic [2:0]       ready_ret,     // bit i = retire slot i, slot 0 oldest
    input  logic [2:0]       excep_ret,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             flush,
    output logic             recovering,
    output logic             deadlock,
    output logic [7:0]       excep_cnt,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam int WD_W  = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [REC_W-1:0] c_REC_LOAD = REC_W'(RECOVER_CYC - 1);
    localparam logic [WD_W-1:0]  c_WD_MAX   = WD_W'(STALL_TIMEOUT);

    localparam logic [1:0] c_S_RUN     = 2'd0;
    localparam logic [1:0] c_S_FLUSH   = 2'd1;
    localparam logic [1:0] c_S_RECOVER = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [REC_W-1:0] r_rec_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [WD_W-1:0]  w_wd_next;
    logic             r_flush;
    logic             r_recovering;
    logic             r_deadlock;
    logic [7:0]       r_excep_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_struct_stall;
    logic             w_excep_hit;
    logic             w_run_stall;

    // Retirement is in order: an exception only matters if every older slot
    // in the same group is also ready.
    assign w_struct_stall = full_PRF | full_RS_add | full_RS_mul |
                            full_RS_agu | full_LSQ | full_ROB;
    assign w_excep_hit    = (ready_ret[0] & excep_ret[0]) |
                            (ready_ret[0] & ready_ret[1] & excep_ret[1]) |
                            (ready_ret[0] & ready_ret[1] & ready_ret[2] & excep_ret[2]);
    assign w_run_stall    = (r_state == c_S_RUN) & w_struct_stall;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; exceptions are ignored outside RUN because the ROB
    // is being flushed anyway.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_RUN: begin
                if (w_excep_hit) begin
                    w_state_next = c_S_FLUSH;
                end
            end
            c_S_FLUSH: begin
                w_state_next = c_S_RECOVER;
            end
            c_S_RECOVER: begin
                if (r_rec_cnt == '0) begin
                    w_state_next = c_S_RUN;
                end
            end
            default: begin
                w_state_next = c_S_RUN;
            end
        endcase
    end

    // Combinational freezes; the detection cycle itself is already frozen.
    always_comb begin
        freeze_front = w_struct_stall | (r_state != c_S_RUN) | w_excep_hit;
        freeze_back  = mem_busy | (r_state == c_S_FLUSH);
    end

    // Registered flush pulse and recovering flag, decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush      <= 1'b0;
            r_recovering <= 1'b0;
        end else begin
            r_flush      <= (w_state_next == c_S_FLUSH);
            r_recovering <= (w_state_next != c_S_RUN);
        end
    end

    // Recovery countdown: loaded leaving FLUSH, so RECOVER lasts RECOVER_CYC cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rec_cnt <= '0;
        end else if (r_state == c_S_FLUSH) begin
            r_rec_cnt <= c_REC_LOAD;
        end else if ((r_state == c_S_RECOVER) && (r_rec_cnt != '0)) begin
            r_rec_cnt <= r_rec_cnt - 1'b1;
        end
    end

    // Flush counter; wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_excep_cnt <= '0;
        end else if (r_state == c_S_FLUSH) begin
            r_excep_cnt <= r_excep_cnt + 8'd1;
        end
    end

    // Saturating count of structural-stall cycles spent in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_run_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // Watchdog: consecutive RUN stall cycles, saturating at the timeout.
    always_comb begin
        w_wd_next = '0;
        if (w_run_stall) begin
            w_wd_next = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;
        end
    end

    // Deadlock is sticky from the edge the watchdog reaches the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt   <= '0;
            r_deadlock <= 1'b0;
        end else begin
            r_wd_cnt   <= w_wd_next;
            r_deadlock <= r_deadlock | (w_wd_next == c_WD_MAX);
        end
    end

    assign flush        = r_flush;
    assign recovering   = r_recovering;
    assign deadlock     = r_deadlock;
    assign excep_cnt    = r_excep_cnt;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_freeze_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_freeze_ctrl
// Description : Self-checking bench for pipe_freeze_ctrl. A cycle-level model
//               tracks the flush/recover window as a remaining-cycle count and
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_freeze_ctrl;

    localparam int RC = 2;
    localparam int TO = 255;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    full_v = '0;      // PRF, RS_add, RS_mul, RS_agu, LSQ, ROB
    logic          mem_busy = 1'b0;
    logic [2:0]    ready_ret = '0;
    logic [2:0]    excep_ret = '0;

    logic          freeze_front, freeze_back, flush, recovering, deadlock;
    logic [7:0]    excep_cnt;
    logic [CW-1:0] stall_cycles;

    logic [28:0]   obs;
    logic [28:0]   exp_v;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int            m_window;  // 0 = running; RC+1 = flush cycle; RC..1 = recover
    int            m_consec;
    logic          m_dead;
    logic [7:0]    m_exc;
    logic [CW-1:0] m_stall;

    pipe_freeze_ctrl #(
        .RECOVER_CYC  (RC),
        .STALL_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .full_PRF    (full_v[0]),
        .full_RS_add (full_v[1]),
        .full_RS_mul (full_v[2]),
        .full_RS_agu (full_v[3]),
        .full_LSQ    (full_v[4]),
        .full_ROB    (full_v[5]),
        .mem_busy    (mem_busy),
        .ready_ret   (ready_ret),
        .excep_ret   (excep_ret),
        .freeze_front(freeze_front),
        .freeze_back (freeze_back),
        .flush       (flush),
        .recovering  (recovering),
        .deadlock    (deadlock),
        .excep_cnt   (excep_cnt),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign obs = {freeze_front, freeze_back, flush, recovering, deadlock, excep_cnt, stall_cycles};

    // Oldest-first scan: stop at the first slot that is not ready.
    function automatic logic model_hit(input logic [2:0] rr, input logic [2:0] ex);
        for (int i = 0; i < 3; i++) begin
            if (!rr[i]) return 1'b0;
            if (ex[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_window = 0;
        m_consec = 0;
        m_dead   = 1'b0;
        m_exc    = '0;
        m_stall  = '0;
    endtask

    // Drive one cycle of inputs (called just after a rising edge), compute the
    // expected outputs, and move to the falling edge for sampling.
    task automatic apply(input logic [5:0] f, input logic mb, input logic [2:0] rr, input logic [2:0] ex);
        logic hit, run, fl;
        full_v = f; mem_busy = mb; ready_ret = rr; excep_ret = ex;
        hit = model_hit(rr, ex);
        run = (m_window == 0);
        fl  = (m_window == RC + 1);
        exp_v = {(|f) | !run | hit, mb | fl, fl, !run, m_dead, m_exc, m_stall};
        @(negedge clk);
    endtask

    // Advance the model across the rising edge using the applied inputs.
    task automatic tick();
        logic hit;
        hit = model_hit(ready_ret, excep_ret);
        @(posedge clk);
        if (m_window == 0) begin
            if (|full_v) begin
                m_consec++;
                if (m_stall != '1) m_stall = m_stall + 1'b1;
            end else begin
                m_consec = 0;
            end
            if (m_consec >= TO) m_dead = 1'b1;
            if (hit) m_window = RC + 1;
        end else begin
            m_consec = 0;
            if (m_window == RC + 1) m_exc = m_exc + 8'd1;
            m_window--;
        end
        #1;
    endtask

    task automatic do_reset();
        full_v = '0; mem_busy = 1'b0; ready_ret = '0; excep_ret = '0;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        full_v = '0; mem_busy = 1'b0; ready_ret = '0; excep_ret = '0;
        rst = 1'b0;
        model_clear();
        #3;
        n_checks++;
        if (obs !== 29'd0) $display("FAIL reset_hold: got %h expected %h", obs, 29'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            apply('0, 1'b0, 3'b000, 3'b000);
            n_checks++;
            if (obs !== 29'd0) $display("FAIL reset_idle c%0d: got %h expected %h", c, obs, 29'd0);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_stall_burst();
        for (int c = 0; c < 7; c++) begin
            apply((c < 5) ? 6'b000100 : 6'b000000, 1'b0, 3'b000, 3'b000);
            n_checks++;
            if (obs !== exp_v) $display("FAIL stall_burst c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (stall_cycles !== 16'd5) $display("FAIL stall_cycles_5: got %0d expected 5", stall_cycles);
        else n_pass++;
    endtask

    task automatic test_exception();
        // ex1 with all three slots ready; mem_busy raised during recovery
        for (int c = 0; c < 7; c++) begin
            apply('0, (c == 2 || c == 3), (c == 0) ? 3'b111 : 3'b000, (c == 0) ? 3'b010 : 3'b000);
            n_checks++;
            if (obs !== exp_v) $display("FAIL exception c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (excep_cnt !== 8'd1) $display("FAIL excep_cnt_1: got %0d expected 1", excep_cnt);
        else n_pass++;
    endtask

    task automatic test_not_oldest();
        int flushes = 0;
        for (int c = 0; c < 4; c++) begin
            apply('0, 1'b0, (c == 0) ? 3'b110 : 3'b000, (c == 0) ? 3'b110 : 3'b000);
            n_checks++;
            if (obs !== exp_v) $display("FAIL not_oldest c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            flushes += int'(flush);
            tick();
        end
        n_checks++;
        if (flushes != 0) $display("FAIL not_oldest_flush: got %0d pulses expected 0", flushes);
        else n_pass++;
    endtask

    task automatic test_held_exception_and_reset();
        int pulses = 0;
        // exception held through FLUSH and RECOVER, dropped exactly on return to RUN
        for (int c = 0; c < 7; c++) begin
            apply('0, 1'b0, (c < 2 + RC) ? 3'b001 : 3'b000, (c < 2 + RC) ? 3'b001 : 3'b000);
            n_checks++;
            if (obs !== exp_v) $display("FAIL held_excep c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            pulses += int'(flush);
            tick();
        end
        n_checks++;
        if (pulses != 1) $display("FAIL held_one_pulse: got %0d expected 1", pulses);
        else n_pass++;
        // new exception, then asynchronous reset while in RECOVER
        apply('0, 1'b0, 3'b001, 3'b001);
        tick();
        apply('0, 1'b0, 3'b000, 3'b000);
        tick();
        apply('0, 1'b0, 3'b000, 3'b000);
        n_checks++;
        if (recovering !== 1'b1) $display("FAIL pre_reset_recovering: got %b expected 1", recovering);
        else n_pass++;
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (obs !== 29'd0) $display("FAIL reset_in_recover: got %h expected %h", obs, 29'd0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_watchdog();
        int first_dead = -1;
        for (int c = 0; c < 256; c++) begin
            apply(6'b010000, 1'b0, 3'b000, 3'b000);
            n_checks++;
            if (obs !== exp_v) $display("FAIL watchdog c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            if (deadlock === 1'b1 && first_dead < 0) first_dead = c;
            tick();
        end
        n_checks++;
        if (first_dead != 255) $display("FAIL deadlock_cycle: got %0d expected 255", first_dead);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            apply('0, 1'b0, 3'b000, 3'b000);
            tick();
        end
        n_checks++;
        if (deadlock !== 1'b1) $display("FAIL deadlock_sticky: got %b expected 1", deadlock);
        else n_pass++;
        do_reset();
        apply('0, 1'b0, 3'b000, 3'b000);
        n_checks++;
        if (deadlock !== 1'b0) $display("FAIL deadlock_cleared: got %b expected 0", deadlock);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [5:0] f;
        logic [2:0] rr, ex;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 6; b++) f[b] = ($urandom_range(0, 11) == 0);
            rr = 3'($urandom_range(0, 7));
            for (int b = 0; b < 3; b++) ex[b] = ($urandom_range(0, 9) == 0);
            apply(f, ($urandom_range(0, 3) == 0), rr, ex);
            n_checks++;
            if (obs !== exp_v) $display("FAIL random c%0d: got %h expected %h", c, obs, exp_v);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_excep_wrap();
        do_reset();
        for (int e = 0; e < 256; e++) begin
            for (int c = 0; c < 3 + RC; c++) begin
                apply('0, 1'b0, (c == 0) ? 3'b111 : 3'b000, (c == 0) ? 3'b100 : 3'b000);
                n_checks++;
                if (obs !== exp_v) $display("FAIL wrap e%0d c%0d: got %h expected %h", e, c, obs, exp_v);
                else n_pass++;
                tick();
            end
        end
        n_checks++;
        if (excep_cnt !== 8'd0) $display("FAIL excep_cnt_wrap: got %0d expected 0", excep_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stall_burst();
        test_exception();
        test_not_oldest();
        test_held_exception_and_reset();
        test_watchdog();
        test_random();
        test_excep_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
